// File: rtl/serial_paralelo_rx.sv
// Receive-side serial-to-parallel converter: hunts the COM character for byte
// alignment, locks after a run of aligned COMs, then presents payload bytes.
module serial_paralelo_rx #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDL        = 8'h7C,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    ACTIVE
  } state_t;

  localparam logic [3:0] LockLast = 4'(LOCK_COUNT - 1);

  state_t     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bitCnt;
  logic [3:0] r_bcCnt;
  logic [7:0] r_dataOut;
  logic       r_validOut;
  logic       r_byteStb;
  logic       r_active;

  logic [7:0] w_srNext;
  logic       w_isCom;
  logic       w_isIdl;
  logic       w_boundary;

  // Decisions are taken on the byte including the bit arriving this edge.
  assign w_srNext   = {r_sr[6:0], data_in};
  assign w_isCom    = (w_srNext == COM);
  assign w_isIdl    = (w_srNext == IDL);
  assign w_boundary = (r_bitCnt == 3'd7);

  always_ff @(posedge clk8f) begin
    if (reset) begin
      r_state    <= SEARCH;
      r_sr       <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_bcCnt    <= 4'd0;
      r_dataOut  <= 8'h00;
      r_validOut <= 1'b0;
      r_byteStb  <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_sr      <= w_srNext;
      r_byteStb <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_isCom) begin
            r_bitCnt <= 3'd0;
            r_bcCnt  <= 4'd1;
            r_state  <= SYNC;
          end
        end
        SYNC: begin
          r_bitCnt <= r_bitCnt + 3'd1;
          if (w_boundary) begin
            if (w_isCom) begin
              if (r_bcCnt == LockLast) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end else begin
                r_bcCnt <= r_bcCnt + 4'd1;
              end
            end else begin
              // A broken COM run means the alignment was a false match.
              r_bcCnt <= 4'd0;
              r_state <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          r_bitCnt <= r_bitCnt + 3'd1;
          if (w_boundary) begin
            r_byteStb <= 1'b1;
            if (w_isCom || w_isIdl) begin
              r_validOut <= 1'b0;
            end else begin
              r_dataOut  <= w_srNext;
              r_validOut <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= SEARCH;
        end
      endcase
    end
  end

  assign data_out  = r_dataOut;
  assign valid_out = r_validOut;
  assign byte_stb  = r_byteStb;
  assign active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx: a bit-history model predicts the
// outputs every cycle, and literal expectations pin the directed scenarios.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDL  = 8'h7C;
  localparam int         LOCK = 4;

  logic       clk8f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int passCount;
  int checkCount;
  bit checkEn;

  serial_paralelo_rx #(
    .COM(COM),
    .IDL(IDL),
    .LOCK_COUNT(LOCK)
  ) dut (
    .clk8f(clk8f),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .byte_stb(byte_stb),
    .active(active)
  );

  initial begin
    clk8f = 1'b0;
    forever #5 clk8f = ~clk8f;
  end

  // Model: every bit since reset is kept; alignment is an anchor bit index.
  logic       hist[$];
  int         mode;
  int         comRun;
  int         anchor;
  int         nBits;
  logic [7:0] win;
  logic [7:0] expData;
  logic       expValid;
  logic       expStb;
  logic       expActive;

  function automatic logic [7:0] lastByte();
    logic [7:0] v;
    int n;
    v = 8'h00;
    n = hist.size();
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = n - 8 + i;
      v = {v[6:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return v;
  endfunction

  initial begin
    mode = 0; comRun = 0; anchor = 0; nBits = 0; win = 8'h00;
    expData = 8'h00; expValid = 1'b0; expStb = 1'b0; expActive = 1'b0;
  end

  always @(posedge clk8f) begin
    if (reset) begin
      hist.delete();
      mode = 0; comRun = 0; anchor = 0;
      expData = 8'h00; expValid = 1'b0; expStb = 1'b0; expActive = 1'b0;
    end else begin
      hist.push_back(data_in);
      nBits  = hist.size();
      win    = lastByte();
      expStb = 1'b0;
      if (mode == 0) begin
        if (win == COM) begin
          mode = 1; anchor = nBits; comRun = 1;
        end
      end else if (((nBits - anchor) % 8) == 0) begin
        if (mode == 1) begin
          if (win == COM) begin
            comRun++;
            if (comRun == LOCK) begin
              mode = 2; expActive = 1'b1;
            end
          end else begin
            mode = 0; comRun = 0;
          end
        end else begin
          expStb = 1'b1;
          if (win != COM && win != IDL) begin
            expData = win; expValid = 1'b1;
          end else begin
            expValid = 1'b0;
          end
        end
      end
    end
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkOutput();
    checkValue("data_out",  int'(data_out),  int'(expData));
    checkValue("valid_out", int'(valid_out), int'(expValid));
    checkValue("byte_stb",  int'(byte_stb),  int'(expStb));
    checkValue("active",    int'(active),    int'(expActive));
  endtask

  always @(negedge clk8f) begin
    if (checkEn) checkOutput();
  end

  task automatic applyStimulus(input logic b, input logic rst);
    reset   = rst;
    data_in = b;
    @(posedge clk8f);
    @(negedge clk8f);
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) applyStimulus(v[i], 1'b0);
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b1);
  endtask

  task automatic lockUp();
    for (int i = 0; i < LOCK; i++) sendByte(COM);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    checkEn    = 1'b0;
    reset      = 1'b1;
    data_in    = 1'b1;
    @(negedge clk8f);

    $display("[TB] test 1: reset then idle zeros");
    doReset(3);
    checkEn = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0);
    checkValue("t1_active", int'(active), 0);
    checkValue("t1_data", int'(data_out), 0);

    $display("[TB] test 2: aligned lock");
    doReset(2);
    sendByte(COM); sendByte(COM); sendByte(COM);
    checkValue("t2_pre_active", int'(active), 0);
    sendByte(COM);
    checkValue("t2_active", int'(active), 1);
    checkValue("t2_stb_lock", int'(byte_stb), 0);
    sendByte(8'h55);
    checkValue("t2_data", int'(data_out), 8'h55);
    checkValue("t2_valid", int'(valid_out), 1);
    checkValue("t2_stb", int'(byte_stb), 1);
    applyStimulus(1'b0, 1'b0);
    checkValue("t2_stb_drop", int'(byte_stb), 0);

    $display("[TB] test 3: 3-bit offset lock");
    doReset(2);
    applyStimulus(1'b1, 1'b0); applyStimulus(1'b0, 1'b0); applyStimulus(1'b1, 1'b0);
    lockUp();
    checkValue("t3_active", int'(active), 1);
    sendByte(8'hF0);
    checkValue("t3_data", int'(data_out), 8'hF0);
    checkValue("t3_valid", int'(valid_out), 1);
    sendByte(8'h3C);
    checkValue("t3_stb_next", int'(byte_stb), 1);
    checkValue("t3_data_next", int'(data_out), 8'h3C);

    $display("[TB] test 4: broken COM run then relock");
    doReset(2);
    sendByte(COM); sendByte(COM); sendByte(COM); sendByte(8'h12);
    checkValue("t4_active_lo", int'(active), 0);
    lockUp();
    checkValue("t4_active", int'(active), 1);
    sendByte(8'h34);
    checkValue("t4_data", int'(data_out), 8'h34);
    checkValue("t4_valid", int'(valid_out), 1);

    $display("[TB] test 5: IDL and COM suppression");
    doReset(2);
    lockUp();
    sendByte(8'h55);
    sendByte(IDL);
    checkValue("t5_idl_valid", int'(valid_out), 0);
    checkValue("t5_idl_data", int'(data_out), 8'h55);
    checkValue("t5_idl_stb", int'(byte_stb), 1);
    sendByte(COM);
    checkValue("t5_com_valid", int'(valid_out), 0);
    checkValue("t5_com_data", int'(data_out), 8'h55);
    checkValue("t5_com_stb", int'(byte_stb), 1);
    sendByte(8'hA5);
    checkValue("t5_data", int'(data_out), 8'hA5);
    checkValue("t5_valid", int'(valid_out), 1);

    $display("[TB] test 6: reset while active");
    applyStimulus(1'b1, 1'b0); applyStimulus(1'b0, 1'b0); applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkValue("t6_rst_active", int'(active), 0);
    checkValue("t6_rst_valid", int'(valid_out), 0);
    checkValue("t6_rst_data", int'(data_out), 0);
    checkValue("t6_rst_stb", int'(byte_stb), 0);
    sendByte(8'h11); sendByte(8'h22);
    checkValue("t6_payload_active", int'(active), 0);
    lockUp();
    sendByte(8'h5A);
    checkValue("t6_data", int'(data_out), 8'h5A);
    checkValue("t6_valid", int'(valid_out), 1);
    checkValue("t6_active", int'(active), 1);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
